// File: rtl/power_seq_pkg.sv
// Shared definitions for the power sequencer: register map offsets,
// per-domain FSM state encoding and reset constants.
package power_seq_pkg;

    localparam logic [3:0] OFF_REQ    = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h1;
    localparam logic [3:0] OFF_BUSY   = 4'h2;
    localparam logic [3:0] OFF_ERR    = 4'h3;
    localparam logic [3:0] OFF_ACK    = 4'h4;
    localparam logic [3:0] OFF_IRQ_EN = 4'h5;

    // Reset value of each power_iso bit: domains start isolated.
    localparam logic ISO_RESET = 1'b1;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_PWR_UP = 3'd1,
        ST_DEISO  = 3'd2,
        ST_ON     = 3'd3,
        ST_ISO    = 3'd4,
        ST_PWR_DN = 3'd5
    } dom_state_t;

    function automatic logic [31:0] domain_mask(input int unsigned n);
        logic [32:0] m;
        m = (33'd1 << n) - 33'd1;
        return m[31:0];
    endfunction

endpackage

// File: rtl/power_domain_fsm.sv
// Single power-domain sequencer: ack synchroniser, delay/timeout counter and
// registered switch/isolation outputs.
module power_domain_fsm
    import power_seq_pkg::*;
#(
    parameter int unsigned ISO_DLY = 4,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic clk,
    input  logic reset_n,
    input  logic req,
    input  logic power_ack,
    output logic power_control,
    output logic power_iso,
    output logic ack_sync,
    output logic on,
    output logic busy,
    output logic err_set
);

    localparam int unsigned CW_TMO = $clog2(TIMEOUT + 1);
    localparam int unsigned CW_DLY = $clog2(ISO_DLY + 1);
    localparam int unsigned CW     = (CW_TMO > CW_DLY) ? CW_TMO : CW_DLY;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] DLY_LOAD = CW'(ISO_DLY);
    localparam logic [CW-1:0] ONE      = CW'(1);

    dom_state_t    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          ctrl_n, iso_n;
    // [1:0] is the two-flop synchroniser; [2] holds the previous synced value.
    logic [2:0]    ack_pipe;
    logic          ack_s, ack_prev;

    assign ack_s    = ack_pipe[1];
    assign ack_prev = ack_pipe[2];
    assign ack_sync = ack_s;
    assign on       = (state == ST_ON);
    assign busy     = (state != ST_ON) && (state != ST_OFF);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_OFF;
            cnt           <= '0;
            power_control <= 1'b0;
            power_iso     <= ISO_RESET;
            ack_pipe      <= '0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            power_control <= ctrl_n;
            power_iso     <= iso_n;
            ack_pipe      <= {ack_pipe[1:0], power_ack};
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ctrl_n  = power_control;
        iso_n   = power_iso;
        err_set = 1'b0;
        case (state)
            ST_OFF: if (req) begin
                state_n = ST_PWR_UP;
                ctrl_n  = 1'b1;
                cnt_n   = '0;
            end
            ST_PWR_UP: begin
                if (ack_s) begin
                    state_n = ST_DEISO;
                    cnt_n   = DLY_LOAD;
                end else if (cnt >= TMO_LAST) begin
                    state_n = ST_OFF;
                    ctrl_n  = 1'b0;
                    err_set = 1'b1;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
            ST_DEISO: begin
                if (cnt <= ONE) begin
                    state_n = ST_ON;
                    iso_n   = 1'b0;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            ST_ON: begin
                err_set = ack_prev && !ack_s;
                if (!req) begin
                    state_n = ST_ISO;
                    iso_n   = 1'b1;
                    cnt_n   = DLY_LOAD;
                end
            end
            ST_ISO: begin
                if (cnt <= ONE) begin
                    state_n = ST_PWR_DN;
                    ctrl_n  = 1'b0;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            ST_PWR_DN: begin
                if (!ack_s) begin
                    state_n = ST_OFF;
                end else if (cnt >= TMO_LAST) begin
                    state_n = ST_OFF;
                    err_set = 1'b1;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
            default: begin
                state_n = ST_OFF;
                ctrl_n  = 1'b0;
                iso_n   = ISO_RESET;
            end
        endcase
    end

endmodule

// File: rtl/power_sequencer.sv
// CPU-programmable power-domain sequencer: register file, decode and read mux
// around one power_domain_fsm per domain. POWER_SEQ_IRQ_EN adds IRQ_EN and irq.
module power_sequencer
    import power_seq_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS = 8,
    parameter logic [13:0] BASE_ADDR   = 14'h400,
    parameter int unsigned ISO_DLY     = 4,
    parameter int unsigned TIMEOUT     = 1023
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [13:0]            per_addr,
    input  logic [31:0]            per_din,
    input  logic                   per_en,
    input  logic                   per_we,
    input  logic                   per_rd,
    output logic [31:0]            per_dout,
    input  logic [NUM_DOMAINS-1:0] power_ack,
    output logic [NUM_DOMAINS-1:0] power_control,
    output logic [NUM_DOMAINS-1:0] power_iso,
    output logic                   irq
);

    localparam logic [31:0] DOM_MASK = domain_mask(NUM_DOMAINS);

    logic                   sel, wr, rd;
    logic [31:0]            req_q, err_q, w1c, rdata;
    logic [NUM_DOMAINS-1:0] on_v, busy_v, ack_v, err_set_v;

    assign sel = per_en && (per_addr[13:4] == BASE_ADDR[13:4]);
    assign wr  = sel && per_we;
    assign rd  = sel && per_rd;
    assign w1c = (wr && per_addr[3:0] == OFF_ERR) ? per_din : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_q <= '0;
            err_q <= '0;
        end else begin
            if (wr && per_addr[3:0] == OFF_REQ)
                req_q <= per_din & DOM_MASK;
            // A new error in the same cycle as its W1C keeps the flag set.
            err_q <= (err_q & ~w1c) | 32'(err_set_v);
        end
    end

`ifdef POWER_SEQ_IRQ_EN
    logic [31:0] irq_en_q;
    logic        irq_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            if (wr && per_addr[3:0] == OFF_IRQ_EN)
                irq_en_q <= per_din & DOM_MASK;
            irq_q <= |(err_q & irq_en_q);
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        if (rd) begin
            case (per_addr[3:0])
                OFF_REQ:    rdata = req_q;
                OFF_STATUS: rdata = 32'(on_v);
                OFF_BUSY:   rdata = 32'(busy_v);
                OFF_ERR:    rdata = err_q;
                OFF_ACK:    rdata = 32'(ack_v);
`ifdef POWER_SEQ_IRQ_EN
                OFF_IRQ_EN: rdata = irq_en_q;
`endif
                default:    rdata = '0;
            endcase
        end
    end

    assign per_dout = rdata;

    for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_dom
        power_domain_fsm #(
            .ISO_DLY(ISO_DLY),
            .TIMEOUT(TIMEOUT)
        ) u_dom (
            .clk          (clk),
            .reset_n      (reset_n),
            .req          (req_q[i]),
            .power_ack    (power_ack[i]),
            .power_control(power_control[i]),
            .power_iso    (power_iso[i]),
            .ack_sync     (ack_v[i]),
            .on           (on_v[i]),
            .busy         (busy_v[i]),
            .err_set      (err_set_v[i])
        );
    end

endmodule

// File: tb/tb_power_sequencer.sv
// Self-checking bench for power_sequencer: timestamp-based behavioural model,
// per-cycle output compare, directed scenarios and randomized bus/ack traffic.
module tb_power_sequencer;

    localparam int ND   = 8;
    localparam int IDLY = 4;
    localparam int TMO  = 1023;
    localparam logic [31:0] MASK = 32'h0000_00FF;
`ifdef POWER_SEQ_IRQ_EN
    localparam bit IRQ_IMPL = 1'b1;
`else
    localparam bit IRQ_IMPL = 1'b0;
`endif

    localparam int P_OFF = 0, P_UP = 1, P_DEISO = 2, P_ON = 3, P_ISO = 4, P_DN = 5;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [13:0]   per_addr = '0;
    logic [31:0]   per_din = '0;
    logic          per_en = 1'b0, per_we = 1'b0, per_rd = 1'b0;
    logic [31:0]   per_dout;
    logic [ND-1:0] power_ack = '0;
    logic [ND-1:0] power_control, power_iso;
    logic          irq;

    int checks = 0;
    int errors = 0;

    power_sequencer #(
        .NUM_DOMAINS(ND),
        .BASE_ADDR  (14'h400),
        .ISO_DLY    (IDLY),
        .TIMEOUT    (TMO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .per_addr     (per_addr),
        .per_din      (per_din),
        .per_en       (per_en),
        .per_we       (per_we),
        .per_rd       (per_rd),
        .per_dout     (per_dout),
        .power_ack    (power_ack),
        .power_control(power_control),
        .power_iso    (power_iso),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    // Behavioural model: each domain has a phase and the edge index it entered it.
    logic [31:0]   req_m, err_m, irqen_m;
    logic          irq_m;
    int            mode  [ND];
    int            since [ND];
    int            edge_n;
    logic [15:0]   ctl_sh [ND];
    logic [ND-1:0] ack_smp [3];

    // Ack stimulus: loopback of the model's control with per-domain delay.
    int            dly [ND];
    logic [ND-1:0] stuck0 = '0;
    logic [ND-1:0] drop = '0;

    function automatic logic ctl_of(input int p);
        return (p == P_UP) || (p == P_DEISO) || (p == P_ON) || (p == P_ISO);
    endfunction

    function automatic logic [ND-1:0] exp_ctl();
        logic [ND-1:0] v;
        for (int i = 0; i < ND; i++) v[i] = ctl_of(mode[i]);
        return v;
    endfunction

    function automatic logic [ND-1:0] exp_iso();
        logic [ND-1:0] v;
        for (int i = 0; i < ND; i++) v[i] = (mode[i] != P_ON);
        return v;
    endfunction

    function automatic logic [31:0] exp_read(input logic [3:0] off);
        logic [31:0] v;
        v = '0;
        case (off)
            4'h0: v = req_m;
            4'h1: for (int i = 0; i < ND; i++) v[i] = (mode[i] == P_ON);
            4'h2: for (int i = 0; i < ND; i++) v[i] = (mode[i] != P_ON) && (mode[i] != P_OFF);
            4'h3: v = err_m;
            4'h4: v = 32'(ack_smp[1]);
            4'h5: v = irqen_m;
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic model_reset();
        req_m = '0; err_m = '0; irqen_m = '0; irq_m = 1'b0; edge_n = 0;
        for (int i = 0; i < ND; i++) begin
            mode[i] = P_OFF; since[i] = 0; ctl_sh[i] = '0;
        end
        for (int k = 0; k < 3; k++) ack_smp[k] = '0;
    endtask

    task automatic model_step();
        logic [ND-1:0] acks, accp, set_v;
        logic [31:0]   w1c;
        int            el;
        edge_n++;
        acks  = ack_smp[1];   // raw ack present two edges ago
        accp  = ack_smp[2];
        set_v = '0;
        w1c   = '0;
        for (int i = 0; i < ND; i++) begin
            el = edge_n - since[i];
            case (mode[i])
                P_OFF:   if (req_m[i]) begin mode[i] = P_UP; since[i] = edge_n; end
                P_UP:    if (acks[i]) begin mode[i] = P_DEISO; since[i] = edge_n; end
                         else if (el == TMO) begin mode[i] = P_OFF; set_v[i] = 1'b1; end
                P_DEISO: if (el == IDLY) mode[i] = P_ON;
                P_ON: begin
                    if (accp[i] && !acks[i]) set_v[i] = 1'b1;
                    if (!req_m[i]) begin mode[i] = P_ISO; since[i] = edge_n; end
                end
                P_ISO:   if (el == IDLY) begin mode[i] = P_DN; since[i] = edge_n; end
                P_DN:    if (!acks[i]) mode[i] = P_OFF;
                         else if (el == TMO) begin mode[i] = P_OFF; set_v[i] = 1'b1; end
                default: mode[i] = P_OFF;
            endcase
            ctl_sh[i] = {ctl_sh[i][14:0], ctl_of(mode[i])};
        end
        irq_m = IRQ_IMPL && ((err_m & irqen_m) != 0);
        if (per_en && per_we && per_addr[13:4] == 10'h040) begin
            case (per_addr[3:0])
                4'h0: req_m = per_din & MASK;
                4'h3: w1c = per_din;
                4'h5: if (IRQ_IMPL) irqen_m = per_din & MASK;
                default: ;
            endcase
        end
        err_m = (err_m & ~w1c) | 32'(set_v);
        ack_smp[2] = ack_smp[1];
        ack_smp[1] = ack_smp[0];
        ack_smp[0] = power_ack;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    always @(posedge clk) begin
        #2;
        for (int i = 0; i < ND; i++)
            power_ack[i] = (stuck0[i] || drop[i]) ? 1'b0 : ctl_sh[i][dly[i]];
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("power_control", 32'(power_control), 32'(exp_ctl()));
        check("power_iso", 32'(power_iso), 32'(exp_iso()));
        check("irq", 32'(irq), 32'(irq_m));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic bus_write_addr(input logic [13:0] addr, input logic [31:0] data);
        per_en = 1'b1; per_we = 1'b1; per_addr = addr; per_din = data;
        tick();
        per_en = 1'b0; per_we = 1'b0;
    endtask

    task automatic bus_write(input logic [3:0] off, input logic [31:0] data);
        bus_write_addr({10'h040, off}, data);
    endtask

    task automatic bus_read_addr(input logic [13:0] addr, output logic [31:0] d);
        per_en = 1'b1; per_rd = 1'b1; per_addr = addr;
        #1;
        d = per_dout;
        per_en = 1'b0; per_rd = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [3:0] off, input logic [31:0] lit);
        logic [31:0] d;
        bus_read_addr({10'h040, off}, d);
        check(name, d, lit);
        check({name, " model"}, exp_read(off), lit);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        logic [31:0] d;
        int          r, i;
        for (int k = 0; k < ND; k++) dly[k] = 0;

        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        tick();

        // Reset state
        for (int k = 0; k < 4; k++) read_check("reset reg", 4'(k), 32'h0);
        check("reset iso", 32'(power_iso), 32'hFF);
        check("reset ctl", 32'(power_control), 32'h0);

        // Power up domain 0, ack 3 cycles after control
        dly[0] = 3;
        bus_write(4'h0, 32'h1);
        check("up ctl0 write edge", 32'(power_control[0]), 32'h0);
        tick();
        check("up ctl0 +1", 32'(power_control[0]), 32'h1);
        repeat (9) tick();
        check("up iso0 +10", 32'(power_iso[0]), 32'h1);
        tick();
        check("up iso0 +11", 32'(power_iso[0]), 32'h0);
        read_check("up status", 4'h1, 32'h1);
        read_check("up busy", 4'h2, 32'h0);
        read_check("up ack", 4'h4, 32'h1);

        // Power down domain 0, ack drops 2 cycles after control
        dly[0] = 2;
        bus_write(4'h0, 32'h0);
        check("dn iso0 write edge", 32'(power_iso[0]), 32'h0);
        tick();
        check("dn iso0 +1", 32'(power_iso[0]), 32'h1);
        repeat (3) tick();
        check("dn ctl0 +4", 32'(power_control[0]), 32'h1);
        tick();
        check("dn ctl0 +5", 32'(power_control[0]), 32'h0);
        repeat (6) tick();
        read_check("dn status", 4'h1, 32'h0);
        read_check("dn busy", 4'h2, 32'h0);

        // REQ toggled during power-up of domain 1
        dly[1] = 3;
        bus_write(4'h0, 32'h2);
        tick();
        bus_write(4'h0, 32'h0);
        repeat (8) tick();
        check("toggle iso1 +10", 32'(power_iso[1]), 32'h1);
        tick();
        check("toggle iso1 +11", 32'(power_iso[1]), 32'h0);
        read_check("toggle status", 4'h1, 32'h2);
        tick();
        check("toggle iso1 +12", 32'(power_iso[1]), 32'h1);
        check("toggle ctl1 +12", 32'(power_control[1]), 32'h1);
        repeat (20) tick();
        read_check("toggle status end", 4'h1, 32'h0);
        read_check("toggle busy end", 4'h2, 32'h0);

        // Domain 7 timeout, set-beats-W1C, irq
        stuck0[7] = 1'b1;
        bus_write(4'h5, 32'h80);
        bus_write(4'h0, 32'h80);
        repeat (1023) tick();
        check("tmo ctl7 before", 32'(power_control[7]), 32'h1);
        bus_write(4'h3, 32'h80);
        check("tmo ctl7", 32'(power_control[7]), 32'h0);
        check("tmo iso7", 32'(power_iso[7]), 32'h1);
        read_check("tmo err set wins", 4'h3, 32'h80);
        check("tmo irq not yet", 32'(irq), 32'h0);
        bus_write(4'h0, 32'h0);
        check("tmo irq", 32'(irq), 32'(IRQ_IMPL));
        check("tmo retry ctl7", 32'(power_control[7]), 32'h1);
        repeat (1024) tick();
        check("tmo2 ctl7", 32'(power_control[7]), 32'h0);
        read_check("tmo2 err", 4'h3, 32'h80);
        bus_write(4'h3, 32'h80);
        read_check("w1c err", 4'h3, 32'h0);
        check("w1c irq lag", 32'(irq), 32'(IRQ_IMPL));
        tick();
        check("w1c irq", 32'(irq), 32'h0);
        stuck0[7] = 1'b0;

        // Asynchronous reset during DEISO of domain 2
        dly[2] = 0;
        bus_write(4'h0, 32'h4);
        repeat (5) tick();
        check("rst pre ctl2", 32'(power_control[2]), 32'h1);
        check("rst pre iso2", 32'(power_iso[2]), 32'h1);
        reset_n = 1'b0;
        #1;
        check("rst ctl", 32'(power_control), 32'h0);
        check("rst iso", 32'(power_iso), 32'hFF);
        check("rst irq", 32'(irq), 32'h0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        read_check("rst status", 4'h1, 32'h0);
        read_check("rst busy", 4'h2, 32'h0);
        read_check("rst req", 4'h0, 32'h0);

        // Randomized traffic
        stuck0 = ND'($urandom) & 8'h30;
        for (int k = 0; k < ND; k++) dly[k] = $urandom_range(0, 6);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) < 3) begin
                i = $urandom_range(0, ND - 1);
                dly[i] = $urandom_range(0, 6);
            end
            if ($urandom_range(0, 99) < 2) begin
                i = $urandom_range(0, ND - 1);
                drop[i] = ~drop[i];
            end
            r = $urandom_range(0, 99);
            if (r < 8) bus_write(4'h0, $urandom);
            else if (r < 11) bus_write(4'h3, $urandom);
            else if (r < 13) bus_write(4'h5, $urandom);
            else if (r < 15) bus_write(4'($urandom_range(6, 15)), $urandom);
            else if (r < 17) bus_write_addr({10'h041, 4'($urandom_range(0, 5))}, $urandom);
            else if (r < 40) begin
                i = $urandom_range(0, 15);
                bus_read_addr({10'h040, 4'(i)}, d);
                check("rand read", d, exp_read(4'(i)));
                tick();
            end else if (r < 43) begin
                bus_read_addr({10'h041, 4'($urandom_range(0, 5))}, d);
                check("rand read other base", d, 32'h0);
                tick();
            end else tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
